alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one instance of the team's combinational `alu` among NREQ requesters, for example the pipeline EX stage and the branch/address helper.
- Arbitration is round-robin.
- The block registers operands into the ALU, captures the result, and returns it on a single response channel tagged with the requester id.
- Only one operation is in flight at a time.

Parameters:
- NREQ, 2, number of requesters (≥2).
- IDW, $clog2(NREQ), width of the requester id.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  NREQ*32  packed operand A; slice i belongs to requester i.
- req_b  in  NREQ*32  packed operand B.
- req_op  in  NREQ*4  packed 4-bit ALU opcode.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer accept.
- rsp_id  out  IDW  index of the requester that owns the response.
- rsp_result  out  32  captured ALU result.
- rsp_zero  out  1  rsp_result == 0.
- rsp_neg  out  1  rsp_result[31].
- rsp_err  out  1  opcode was illegal; the ALU was not used.
- busy  out  1  state != IDLE.

Behaviour:
- Legal opcodes:
  - ADD 4'b0000, SUB 4'b0010, SLT 4'b1010 (unsigned compare, result 1/0).
  - AND 4'b0100, OR 4'b0101, NOR 4'b0111.
  - All other codes are illegal.
- FSM states:
  - IDLE: arbitrate.
  - EXEC: one cycle; the ALU inputs are driven from registers op_a/op_b/op_code.
  - RESP: hold the response.
- IDLE:
  - If any req_valid is set, grant g = first set bit searching from last_grant+1 modulo NREQ.
  - req_ready[g] = 1 combinationally in the same cycle; the handshake completes on that edge.
  - Latch a, b, op and id.
  - Update last_grant = g.
  - Legal op: go to EXEC. Illegal op: go to RESP with rsp_result = 0 and rsp_err = 1.
- EXEC:
  - At the end of the cycle, capture the ALU result into rsp_result and go to RESP.
  - rsp_zero and rsp_neg are computed from the captured result, not taken from the ALU flag outputs.
- RESP:
  - rsp_valid = 1.
  - rsp_id, rsp_result, rsp_zero, rsp_neg and rsp_err are stable until rsp_valid && rsp_ready.
  - On that handshake go to IDLE. There is no accept in the same cycle.
- req_ready is 0 in EXEC and RESP.
- Latency: request accepted at edge N; rsp_valid high from edge N+2 (legal op) or N+1 (illegal op).
- Best-case throughput: one op per 3 cycles.
- Requesters hold valid and payload until ready. A requester deasserting valid before grant is legal and has no effect.
- Simultaneous requests: only one is granted per IDLE cycle. The others wait, and fairness is guaranteed by the round-robin pointer.
- Reset values: state = IDLE, last_grant = NREQ-1 (requester 0 wins first). All outputs are 0: rsp_valid, rsp_*, req_ready, busy.
- ALU operand registers reset to 0 with op_code = ADD, so the ALU output is defined (0) out of reset.
- Reset asserted mid-operation: the in-flight op is discarded with no response, and all state returns to reset values immediately (asynchronous).
- Arithmetic is 32-bit wrap-around. SUB does not saturate, and no overflow flag is produced.

Decomposition:
- Package alu_pkg holds:
  - Opcode localparams: ALUOP_ADD, ALUOP_SUB, ALUOP_SLT, ALUOP_AND, ALUOP_OR, ALUOP_NOR.
  - function op_legal(op).
  - FSM state encoding: IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2.
- Sub-module rr_arbiter(NREQ): inputs req, pointer and enable; outputs a one-hot grant and its index. It is combinational, and the pointer register stays in alu_arbiter.
- alu_arbiter instantiates `alu` directly. Its aluop input is tied to op_code.

Test Plan:
1. Reset then requester 0: ADD a=5, b=7 → req_ready[0] in the same cycle; rsp_valid 2 cycles later with rsp_result = 12, zero = 0, neg = 0, id = 0, err = 0.
2. Requester 1: SUB a=3, b=5 → rsp_result = 32'hFFFFFFFE, neg = 1, zero = 0. Then SLT a=3, b=5 → rsp_result = 1. Then SUB a=9, b=9 → rsp_result = 0, zero = 1.
3. Both requesters continuously valid for 4 transactions → grants alternate 0, 1, 0, 1, and each rsp_id matches its grant.
4. Illegal op 4'b0001 from requester 1 → response after 1 cycle with rsp_err = 1 and result 0. A following legal NOR a=0, b=0 returns 32'hFFFFFFFF with err = 0.
5. Hold rsp_ready low for 5 cycles during RESP → response fields stable, req_ready stays 0 and busy stays 1. Release → IDLE on the next edge.
6. Assert rst_n low during EXEC → all outputs 0 immediately and no response is produced. After release, requester 0 wins first.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, legality check, arbiter FSM states.
package alu_pkg;

    localparam logic [3:0] ALUOP_ADD = 4'b0000;
    localparam logic [3:0] ALUOP_SUB = 4'b0010;
    localparam logic [3:0] ALUOP_SLT = 4'b1010;
    localparam logic [3:0] ALUOP_AND = 4'b0100;
    localparam logic [3:0] ALUOP_OR  = 4'b0101;
    localparam logic [3:0] ALUOP_NOR = 4'b0111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    function automatic logic op_legal(input logic [3:0] op);
        logic legal;
        case (op)
            ALUOP_ADD, ALUOP_SUB, ALUOP_SLT,
            ALUOP_AND, ALUOP_OR,  ALUOP_NOR: legal = 1'b1;
            default:                         legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU; illegal opcodes produce 0.
module alu
    import alu_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [3:0]  aluop_i,
    output logic [31:0] result_o
);

    // Operation select; SLT is an unsigned compare
    always_comb begin
        result_o = '0;
        case (aluop_i)
            ALUOP_ADD: result_o = a_i + b_i;
            ALUOP_SUB: result_o = a_i - b_i;
            ALUOP_SLT: result_o = {31'b0, (a_i < b_i)};
            ALUOP_AND: result_o = a_i & b_i;
            ALUOP_OR:  result_o = a_i | b_i;
            ALUOP_NOR: result_o = ~(a_i | b_i);
            default:   result_o = '0;
        endcase
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past the pointer.
module rr_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    input  logic            en_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  idx_o,
    output logic            vld_o
);

    logic [IDW-1:0] cand;

    // First requester found from ptr_i+1 (mod NREQ) wins
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        cand  = '0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            cand = IDW'((32'(ptr_i) + off) % NREQ);
            if (en_i && !vld_o && req_i[cand]) begin
                vld_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NREQ requesters, one op in flight.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*32-1:0] req_a,
    input  logic [NREQ*32-1:0] req_b,
    input  logic [NREQ*4-1:0]  req_op,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [31:0]        rsp_result,
    output logic               rsp_zero,
    output logic               rsp_neg,
    output logic               rsp_err,
    output logic               busy
);

    arb_state_e     state_q, state_d;
    logic [IDW-1:0] last_q, last_d;
    logic [31:0]    a_q, a_d, b_q, b_d;
    logic [3:0]     op_q, op_d;
    logic [IDW-1:0] id_q, id_d;
    logic [31:0]    res_q, res_d;
    logic           zero_q, zero_d, neg_q, neg_d, err_q, err_d;

    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gidx;
    logic            gvld;
    logic [31:0]     sel_a, sel_b, alu_res;
    logic [3:0]      sel_op;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
        .req_i (req_valid),
        .ptr_i (last_q),
        .en_i  (state_q == IDLE),
        .gnt_o (gnt),
        .idx_o (gidx),
        .vld_o (gvld)
    );

    alu u_alu (
        .a_i      (a_q),
        .b_i      (b_q),
        .aluop_i  (op_q),
        .result_o (alu_res)
    );

    // Payload mux driven by the one-hot grant
    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_a  = req_a[i*32 +: 32];
                sel_b  = req_b[i*32 +: 32];
                sel_op = req_op[i*4 +: 4];
            end
        end
    end

    // Next-state and datapath updates for IDLE -> EXEC -> RESP
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        id_d    = id_q;
        res_d   = res_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (gvld) begin
                    a_d    = sel_a;
                    b_d    = sel_b;
                    op_d   = sel_op;
                    id_d   = gidx;
                    last_d = gidx;
                    if (op_legal(sel_op)) begin
                        state_d = EXEC;
                    end else begin
                        // Illegal op bypasses the ALU and answers with a zero result
                        res_d   = '0;
                        zero_d  = 1'b1;
                        neg_d   = 1'b0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            EXEC: begin
                res_d   = alu_res;
                zero_d  = (alu_res == '0);
                neg_d   = alu_res[31];
                err_d   = 1'b0;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight op
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= IDW'(NREQ - 1);
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= ALUOP_ADD;
            id_q    <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            id_q    <= id_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            err_q   <= err_d;
        end
    end

    assign req_ready  = gnt;
    assign rsp_valid  = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign rsp_id     = id_q;
    assign rsp_result = res_q;
    assign rsp_zero   = zero_q;
    assign rsp_neg    = neg_q;
    assign rsp_err    = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed stimulus with a response scoreboard.
module tb_alu_arbiter;

    localparam int NREQ = 2;
    localparam int IDW  = 1;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*32-1:0] req_a;
    logic [NREQ*32-1:0] req_b;
    logic [NREQ*4-1:0]  req_op;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [31:0]        rsp_result;
    logic               rsp_zero, rsp_neg, rsp_err, busy;

    alu_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_neg    (rsp_neg),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        int          id;
        logic [31:0] res;
        logic        zero;
        logic        neg;
        logic        err;
        int          rcyc;
        int          lat;
    } exp_t;

    exp_t sb[$];

    logic [3:0] legal_ops [6] = '{4'b0000, 4'b0010, 4'b1010, 4'b0100, 4'b0101, 4'b0111};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_legal(input logic [3:0] op);
        return (op == 4'b0000) || (op == 4'b0010) || (op == 4'b1010) ||
               (op == 4'b0100) || (op == 4'b0101) || (op == 4'b0111);
    endfunction

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'b0000: return a + b;
            4'b0010: return a - b;
            4'b1010: return (a < b) ? 32'd1 : 32'd0;
            4'b0100: return a & b;
            4'b0101: return a | b;
            4'b0111: return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    task automatic push_exp(input int rid, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] op, input int rc);
        exp_t e;
        e.id   = rid;
        e.res  = ref_legal(op) ? alu_ref(op, a, b) : 32'd0;
        e.zero = (e.res == 32'd0);
        e.neg  = e.res[31];
        e.err  = !ref_legal(op);
        e.rcyc = rc;
        e.lat  = ref_legal(op) ? 2 : 1;
        sb.push_back(e);
    endtask

    task automatic set_payload(input int rid, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        req_a[rid*32 +: 32] = a;
        req_b[rid*32 +: 32] = b;
        req_op[rid*4 +: 4]  = op;
    endtask

    // Call shortly after a rising edge; returns shortly after the accepting edge
    task automatic issue(input int rid, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input bit exp_rsp, output int rc, output int waits);
        set_payload(rid, a, b, op);
        req_valid[rid] = 1'b1;
        waits = 0;
        rc = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready[rid]) begin
                chk("busy_at_grant", busy, 0);
                chk("ready_onehot", req_ready, 64'(1) << rid);
                rc = cyc;
                if (exp_rsp) push_exp(rid, a, b, op, rc);
                @(posedge clk);
                #1;
                req_valid[rid] = 1'b0;
                return;
            end
            waits++;
        end
        chk("grant_timeout", 0, 1);
        req_valid[rid] = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        chk("idle_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    // Response monitor: pops the scoreboard on every response handshake
    initial begin
        bit prev_v;
        int start_cyc;
        exp_t e;
        prev_v = 1'b0;
        start_cyc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 1'b0;
            end else begin
                if (rsp_valid && !prev_v) start_cyc = cyc;
                prev_v = rsp_valid;
                if (rsp_valid && rsp_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_rsp", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_id", rsp_id, e.id);
                        chk("rsp_result", rsp_result, e.res);
                        chk("rsp_zero", rsp_zero, e.zero);
                        chk("rsp_neg", rsp_neg, e.neg);
                        chk("rsp_err", rsp_err, e.err);
                        chk("rsp_latency", start_cyc - e.rcyc, e.lat);
                    end
                end
            end
        end
    end

    initial begin
        int rc, w, rel, k, g;
        int order [4] = '{0, 1, 0, 1};
        logic [31:0] s_res;
        logic [IDW-1:0] s_id;
        logic s_zero, s_neg, s_err;

        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_rsp_zero", rsp_zero, 0);
        chk("rst_rsp_err", rsp_err, 0);
        rst_n = 1'b1;

        // 1: ADD from requester 0, ready in the same cycle
        issue(0, 32'd5, 32'd7, 4'b0000, 1, rc, w);
        chk("t1_same_cycle_ready", w, 0);
        wait_idle();

        // 2: SUB / SLT / SUB-to-zero from requester 1
        issue(1, 32'd3, 32'd5, 4'b0010, 1, rc, w);
        wait_idle();
        issue(1, 32'd3, 32'd5, 4'b1010, 1, rc, w);
        wait_idle();
        issue(1, 32'd9, 32'd9, 4'b0010, 1, rc, w);
        wait_idle();

        // 3: both requesters continuously valid, grants alternate
        set_payload(0, $urandom, $urandom, legal_ops[$urandom_range(5)]);
        set_payload(1, $urandom, $urandom, legal_ops[$urandom_range(5)]);
        req_valid = 2'b11;
        k = 0;
        for (int i = 0; i < 60 && k < 4; i++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                g = req_ready[1] ? 1 : 0;
                chk("t3_onehot", $countones(req_ready), 1);
                chk("t3_grant_order", g, order[k]);
                push_exp(g, req_a[g*32 +: 32], req_b[g*32 +: 32], req_op[g*4 +: 4], cyc);
                k++;
                @(posedge clk);
                #1;
                if (k == 4) req_valid = '0;
                else set_payload(g, $urandom, $urandom, legal_ops[$urandom_range(5)]);
            end
        end
        req_valid = '0;
        if (k < 4) chk("t3_grant_count", k, 4);
        wait_idle();

        // 4: illegal op, then NOR of zeros
        issue(1, 32'd3, 32'd4, 4'b0001, 1, rc, w);
        wait_idle();
        issue(1, 32'd0, 32'd0, 4'b0111, 1, rc, w);
        wait_idle();

        // 5: response back-pressure
        rsp_ready = 1'b0;
        issue(0, 32'h8000_0001, 32'h0000_0001, 4'b0000, 1, rc, w);
        for (int i = 0; i < 10 && !rsp_valid; i++) @(negedge clk);
        chk("t5_rsp_valid", rsp_valid, 1);
        s_res  = rsp_result;
        s_id   = rsp_id;
        s_zero = rsp_zero;
        s_neg  = rsp_neg;
        s_err  = rsp_err;
        set_payload(1, 32'd100, 32'd58, 4'b0010);
        req_valid[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_hold_valid", rsp_valid, 1);
            chk("t5_hold_result", rsp_result, s_res);
            chk("t5_hold_id", rsp_id, s_id);
            chk("t5_hold_flags", {rsp_zero, rsp_neg, rsp_err}, {s_zero, s_neg, s_err});
            chk("t5_hold_ready", req_ready, 0);
            chk("t5_hold_busy", busy, 1);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        rel = cyc;
        issue(1, 32'd100, 32'd58, 4'b0010, 1, rc, w);
        chk("t5_idle_next_edge", rc - rel, 1);
        wait_idle();

        // 6: reset while in EXEC
        issue(0, 32'd1, 32'd2, 4'b0000, 0, rc, w);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_rsp_valid", rsp_valid, 0);
        chk("t6_rst_req_ready", req_ready, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_rsp_result", rsp_result, 0);
        chk("t6_rst_rsp_id", rsp_id, 0);
        chk("t6_rst_flags", {rsp_zero, rsp_neg, rsp_err}, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t6_no_rsp", rsp_valid, 0);
        end
        rst_n = 1'b1;
        set_payload(0, 32'd11, 32'd22, 4'b0101);
        set_payload(1, 32'd33, 32'd44, 4'b0100);
        req_valid = 2'b11;
        #1;
        chk("t6_first_grant", req_ready, 2'b01);
        if (req_ready == 2'b01) push_exp(0, 32'd11, 32'd22, 4'b0101, cyc);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        issue(1, 32'd33, 32'd44, 4'b0100, 1, rc, w);
        wait_idle();

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
